// File: rtl/matrix_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matrix_scan
// Brief    : 8x8 LED matrix row scanner with 16-level PWM per column.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan #(
    parameter int CLK_DIV      = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        rd_en,
    output logic [2:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_n,
    output logic        frame_start
);

    localparam logic [15:0] c_presc_last = 16'(CLK_DIV - 1);
    localparam logic [7:0]  c_blank_last = 8'(BLANK_CYCLES - 1);
    localparam logic [3:0]  c_slot_last  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_BLANK   = 3'd3,
        S_DISPLAY = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_row;
    logic [2:0]  w_row_next;
    logic [3:0]  r_slot;
    logic [3:0]  w_slot_next;
    logic [15:0] r_presc;
    logic [15:0] w_presc_next;
    logic [7:0]  r_blank;
    logic [7:0]  w_blank_next;
    logic [31:0] r_line;
    logic [31:0] w_line_next;
    logic [7:0]  w_lit;

    logic        r_rd_en;
    logic [2:0]  r_rd_addr;
    logic [7:0]  r_row_sel;
    logic [7:0]  r_col_n;
    logic        r_frame_start;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= 3'd0;
            r_slot  <= 4'd0;
            r_presc <= 16'd0;
            r_blank <= 8'd0;
            r_line  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_slot  <= w_slot_next;
            r_presc <= w_presc_next;
            r_blank <= w_blank_next;
            r_line  <= w_line_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_slot_next  = r_slot;
        w_presc_next = r_presc;
        w_blank_next = r_blank;
        w_line_next  = r_line;
        if (!enable) begin
            // Dropping enable abandons the current row but keeps the row index
            w_state_next = S_IDLE;
            w_slot_next  = 4'd0;
            w_presc_next = 16'd0;
            w_blank_next = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_FETCH;
                end
                S_FETCH: begin
                    w_state_next = S_LOAD;
                end
                S_LOAD: begin
                    w_line_next  = rd_data;
                    w_blank_next = 8'd0;
                    w_state_next = S_BLANK;
                end
                S_BLANK: begin
                    if (r_blank == c_blank_last) begin
                        w_blank_next = 8'd0;
                        w_slot_next  = 4'd0;
                        w_presc_next = 16'd0;
                        w_state_next = S_DISPLAY;
                    end else begin
                        w_blank_next = r_blank + 8'd1;
                    end
                end
                S_DISPLAY: begin
                    if (r_presc == c_presc_last) begin
                        w_presc_next = 16'd0;
                        if (r_slot == c_slot_last) begin
                            w_slot_next  = 4'd0;
                            w_row_next   = r_row + 3'd1;
                            w_state_next = S_FETCH;
                        end else begin
                            w_slot_next = r_slot + 4'd1;
                        end
                    end else begin
                        w_presc_next = r_presc + 16'd1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // A column is lit while its brightness exceeds the slot that will be shown
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_col
            assign w_lit[gi] = (r_line[4*gi +: 4] > w_slot_next);
        end
    endgenerate

    // Outputs are registered from next-state values so they align with r_state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en       <= 1'b0;
            r_rd_addr     <= 3'd0;
            r_row_sel     <= 8'h00;
            r_col_n       <= 8'hFF;
            r_frame_start <= 1'b0;
        end else begin
            r_rd_en       <= (w_state_next == S_FETCH);
            r_rd_addr     <= w_row_next;
            r_frame_start <= (w_state_next == S_FETCH) && (w_row_next == 3'd0);
            if (w_state_next == S_DISPLAY) begin
                r_row_sel <= 8'd1 << w_row_next;
                r_col_n   <= ~w_lit;
            end else begin
                r_row_sel <= 8'h00;
                r_col_n   <= 8'hFF;
            end
        end
    end

    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    assign row_sel     = r_row_sel;
    assign col_n       = r_col_n;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan
// Brief    : Directed self-checking bench for matrix_scan (CLK_DIV=2, BLANK=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan;

    localparam int CLK_DIV      = 2;
    localparam int BLANK_CYCLES = 2;
    localparam int ROW_PERIOD   = 2 + BLANK_CYCLES + 16 * CLK_DIV;
    localparam int FRAME        = 8 * ROW_PERIOD;
    localparam int DISP_START   = 2 + BLANK_CYCLES;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  row_sel;
    logic [7:0]  col_n;
    logic        frame_start;

    logic [31:0] fb [8];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit armed    = 1'b0;
    logic prev_rd_en = 1'b0;

    int err_en, err_addr, err_fs, err_rs, err_cn;
    int cnt_en, cnt_fs, cnt_rs01, cnt_rs01_on, cnt08_fe, cnt08_ff, cnt_other_lit;
    int lit [8];

    always #5 clk = ~clk;

    matrix_scan #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .row_sel     (row_sel),
        .col_n       (col_n),
        .frame_start (frame_start)
    );

    // Frame buffer: word valid one cycle after rd_en, noise otherwise
    always @(posedge clk)
        rd_data <= (rd_en === 1'b1) ? fb[rd_addr] : $urandom();

    always @(negedge clk) begin
        if (armed) begin
            n_assert++;
            assert (((row_sel & (row_sel - 8'd1)) == 8'd0) &&
                    ((row_sel == 8'd0) || (dut.r_state == 3'd4)) &&
                    !(rd_en && prev_rd_en))
            else begin
                n_fail++;
                $error("FAIL checker: row_sel=%0h state=%0d rd_en=%0b prev_rd_en=%0b required onehot0/display/no-back-to-back",
                       row_sel, dut.r_state, rd_en, prev_rd_en);
            end
            prev_rd_en = rd_en;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_col_n(input logic [31:0] w, input int slot);
        logic [7:0] v;
        v = 8'hFF;
        for (int c = 0; c < 8; c++)
            if (int'(w[4*c +: 4]) > slot) v[c] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_stats();
        err_en = 0; err_addr = 0; err_fs = 0; err_rs = 0; err_cn = 0;
        cnt_en = 0; cnt_fs = 0; cnt_rs01 = 0; cnt_rs01_on = 0;
        cnt08_fe = 0; cnt08_ff = 0; cnt_other_lit = 0;
        for (int c = 0; c < 8; c++) lit[c] = 0;
    endtask

    // Compare outputs at cycle cyc (0 = first fetch of row 0) with the model
    task automatic sample();
        int p;
        int r;
        logic       e_en;
        logic       e_fs;
        logic [7:0] e_rs;
        logic [7:0] e_cn;
        p    = cyc % ROW_PERIOD;
        r    = (cyc / ROW_PERIOD) % 8;
        e_en = (p == 0);
        e_fs = (p == 0) && (r == 0);
        if (p >= DISP_START) begin
            e_rs = 8'd1 << r;
            e_cn = exp_col_n(fb[r], (p - DISP_START) / CLK_DIV);
        end else begin
            e_rs = 8'h00;
            e_cn = 8'hFF;
        end
        if (rd_en !== e_en) err_en++;
        if (p == 0 && rd_addr !== 3'(r)) err_addr++;
        if (frame_start !== e_fs) err_fs++;
        if (row_sel !== e_rs) err_rs++;
        if (col_n !== e_cn) err_cn++;
        if (rd_en === 1'b1) cnt_en++;
        if (frame_start === 1'b1) cnt_fs++;
        if (row_sel === 8'h01) begin
            cnt_rs01++;
            if (col_n === 8'h00) cnt_rs01_on++;
            if (cyc < FRAME)
                for (int c = 0; c < 8; c++) if (col_n[c] === 1'b0) lit[c]++;
        end
        if (row_sel === 8'h08) begin
            if (col_n === 8'hFE) cnt08_fe++;
            if (col_n === 8'hFF) cnt08_ff++;
        end else if (col_n !== 8'hFF) begin
            cnt_other_lit++;
        end
    endtask

    task automatic observe(input int n);
        repeat (n) begin
            tick();
            sample();
        end
    endtask

    task automatic start_scan();
        int waited;
        waited = 0;
        reset  = 1'b1;
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_stats();
        do begin
            tick();
            waited++;
        end while (rd_en !== 1'b1 && waited < 20);
        check("first_fetch_latency", waited, 1);
        cyc = 0;
        sample();
    endtask

    task automatic check_model(input string s);
        check({s, "_rd_en"}, err_en, 0);
        check({s, "_rd_addr"}, err_addr, 0);
        check({s, "_frame_start"}, err_fs, 0);
        check({s, "_row_sel"}, err_rs, 0);
        check({s, "_col_n"}, err_cn, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) fb[i] = 32'h0;
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_row_sel", row_sel, 8'h00);
        check("rst_col_n", col_n, 8'hFF);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_frame_start", frame_start, 0);
        armed = 1'b1;

        // All rows at full brightness, nine row periods
        for (int i = 0; i < 8; i++) fb[i] = 32'hFFFFFFFF;
        start_scan();
        observe(FRAME + ROW_PERIOD - 1);
        check_model("s1");
        check("s1_rd_en_count", cnt_en, 9);
        check("s1_frame_start_count", cnt_fs, 2);
        check("s1_row0_lit_cycles", cnt_rs01, 64);
        check("s1_row0_all_on_cycles", cnt_rs01_on, 60);

        // Only row 3, column 0 at brightness 15
        for (int i = 0; i < 8; i++) fb[i] = 32'h0;
        fb[3] = 32'h0000000F;
        start_scan();
        observe(FRAME - 1);
        check_model("s2");
        check("s2_row3_col0_on", cnt08_fe, 30);
        check("s2_row3_dark", cnt08_ff, 2);
        check("s2_other_rows_lit", cnt_other_lit, 0);

        // Graded brightness on row 0
        for (int i = 0; i < 8; i++) fb[i] = 32'h0;
        fb[0] = 32'h87654321;
        start_scan();
        observe(FRAME - 1);
        check_model("s3");
        for (int c = 0; c < 8; c++) check($sformatf("s3_col%0d_on_cycles", c), lit[c], 2 * (c + 1));

        // Enable dropped during row 5 display
        for (int i = 0; i < 8; i++) fb[i] = 32'hFFFFFFFF;
        start_scan();
        observe(5 * ROW_PERIOD + DISP_START + 10);
        check_model("s4");
        check("s4_row5_displayed", row_sel, 8'h20);
        enable = 1'b0;
        tick();
        check("s4_off_row_sel", row_sel, 8'h00);
        check("s4_off_col_n", col_n, 8'hFF);
        check("s4_off_rd_en", rd_en, 0);
        repeat (3) tick();
        check("s4_idle_rd_en", rd_en, 0);
        enable = 1'b1;
        tick();
        check("s4_resume_rd_en", rd_en, 1);
        check("s4_resume_rd_addr", rd_addr, 5);
        check("s4_resume_frame_start", frame_start, 0);

        // Reset pulse during row 6 display
        start_scan();
        observe(6 * ROW_PERIOD + DISP_START + 8);
        check("s5_row6_displayed", row_sel, 8'h40);
        reset = 1'b1;
        tick();
        check("s5_rst_row_sel", row_sel, 8'h00);
        check("s5_rst_col_n", col_n, 8'hFF);
        check("s5_rst_rd_en", rd_en, 0);
        check("s5_rst_frame_start", frame_start, 0);
        reset = 1'b0;
        tick();
        check("s5_restart_rd_en", rd_en, 1);
        check("s5_restart_rd_addr", rd_addr, 0);
        check("s5_restart_frame_start", frame_start, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 64: clock cycles per PWM slot, legal range 1..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 4: dark cycles inserted before each row is lit, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port enable, input, 1 bit: scanning runs while this is high.
REQ-006 SHALL have port rd_en, output, 1 bit: frame-buffer read strobe.
REQ-007 SHALL have port rd_addr, output, 3 bits: frame-buffer row address.
REQ-008 SHALL have port rd_data, input, 32 bits: frame-buffer row word, valid exactly 1 cycle after rd_en.
REQ-009 SHALL have port row_sel, output, 8 bits: row drive, active-high, at most one bit set.
REQ-010 SHALL have port col_n, output, 8 bits: column drive, active-low.
REQ-011 SHALL have port frame_start, output, 1 bit: single-cycle pulse when the row 0 fetch is issued.

Function
REQ-012 SHALL treat each row word as 8 pixels; column c brightness is rd_data[4c+3:4c], 0..15.
REQ-013 SHALL implement states IDLE, FETCH, LOAD, BLANK and DISPLAY.
REQ-014 SHALL go IDLE->FETCH on the cycle after enable is sampled high in IDLE; the row counter keeps its value.
REQ-015 SHALL, in FETCH, hold rd_en=1 and rd_addr=row for exactly 1 cycle, then go to LOAD.
REQ-016 SHALL, in LOAD, capture rd_data into an internal 32-bit line register, then go to BLANK.
REQ-017 SHALL stay in BLANK for exactly BLANK_CYCLES cycles, then go to DISPLAY with slot=0 and prescaler=0.
REQ-018 SHALL, in DISPLAY, run 16 slots (0..15) of CLK_DIV cycles each, i.e. 16*CLK_DIV cycles total.
REQ-019 SHALL, in DISPLAY, drive row_sel = 1<<row and col_n[c] = 0 exactly when line brightness[c] > slot.
REQ-020 Duty follows: brightness 0 is never lit; brightness 15 is lit for 15 of 16 slots.
REQ-021 SHALL drive row_sel=8'h00 and col_n=8'hFF in every state other than DISPLAY.
REQ-022 SHALL, after slot 15 completes, increment row modulo 8 (7 wraps to 0) and go to FETCH.
REQ-023 Row period SHALL be 2 + BLANK_CYCLES + 16*CLK_DIV cycles; the full frame is 8 row periods.
REQ-024 SHALL assert frame_start for 1 cycle, together with rd_en, only on a FETCH with row=0.
REQ-025 SHALL return to IDLE on the next edge whenever enable is sampled low in any state; outputs blank from that edge, rd_en=0, row counter held.
REQ-026 SHALL NOT apply rd_data to the outputs except through the LOAD capture; frame-buffer writes take effect at that row's next fetch.
REQ-027 rd_en SHALL be low in all states except FETCH.
REQ-028 Registered outputs: row_sel, col_n, rd_en, rd_addr and frame_start all come from flops.

Reset
REQ-029 On reset, SHALL set state=IDLE, row=0, slot=0, prescaler=0 and line register=0.
REQ-030 On reset, SHALL drive row_sel=8'h00, col_n=8'hFF, rd_en=0, rd_addr=0 and frame_start=0 from the following edge.
REQ-031 Reset asserted mid-DISPLAY SHALL blank the outputs within 1 cycle; after release, the scan restarts at row 0 if enable is high.
REQ-032 Reset SHALL take priority over enable and over all state transitions.

Verification (CLK_DIV=2, BLANK_CYCLES=2, row period 36 cycles)
REQ-033 Scenario: reset, then enable=1, with all rows holding 32'hFFFFFFFF -> rd_en pulses with rd_addr 0,1,...,7,0 every 36 cycles; frame_start pulses every 288 cycles; row_sel is 8'h01 for 32 cycles per row visit with col_n=8'h00 for the first 30 of them.
REQ-034 Scenario: row 3 = 32'h0000000F (column 0 at brightness 15), others 0 -> while row_sel=8'h08, col_n=8'hFE for 30 cycles and 8'hFF for 2; col_n=8'hFF throughout every other row.
REQ-035 Scenario: row 0 = 32'h87654321 -> during row 0's DISPLAY, the count of cycles with col_n[c]=0 equals 2*(c+1) for c=0..7.
REQ-036 Scenario: enable dropped mid-DISPLAY of row 5 -> the next edge gives row_sel=0 and col_n=8'hFF; re-enable gives FETCH with rd_addr=5.
REQ-037 Scenario: reset pulsed for 1 cycle mid-DISPLAY of row 6 -> outputs blank at the next edge; the next fetch has rd_addr=0 with frame_start=1.
REQ-038 Checker, always on: row_sel is one-hot or zero; row_sel!=0 implies state DISPLAY; rd_en never high for 2 consecutive cycles.
